// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  // addi x0, x0, 0 -- presented on if_instr whenever nothing valid is at the head
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Redirect targets only have their two low bits cleared
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush.
// Clear wins over push/pop; a push into a full FIFO is ignored unless a pop frees a slot.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[CW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; pointers alone decide what is live, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues word fetches on a request/response port,
// buffers {pc, instr} pairs, honours stalls and EX-stage redirects.
// Optional macro FETCH_QUEUE_BYPASS_EN: a response arriving at an empty queue
// drives if_* in the same cycle and is only buffered if not consumed.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [31:0]   imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          stall,
  output logic          if_valid,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_pc_plus_4,
  output logic [31:0]   if_instr,
  output logic [CW-1:0] o_occupancy
);

  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  fetch_state_e  state, state_nxt;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] outstanding, drop_cnt, drop_nxt, fifo_count;
  logic [CW:0]   credits_used;
  logic          hs, rsp_drop, rsp_accept, push, pop, fifo_empty, bypass, head_valid;
  fetch_entry_t  fifo_head, rsp_entry, head_sel;

  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign hs           = imem_req_valid && imem_req_ready;
  assign rsp_drop     = imem_rsp_valid && (drop_cnt != '0);
  // A response landing with a redirect is stale by definition
  assign rsp_accept   = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign rsp_entry    = '{pc: rsp_pc, instr: imem_rsp_data};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = fifo_empty && (drop_cnt == '0) && imem_rsp_valid &&
                  !redirect_valid && (state != HOLD);
`else
  assign bypass = 1'b0;
`endif

  // Bypassed data only needs buffering when the consumer is stalled
  assign push = rsp_accept && !(bypass && !stall);
  assign pop  = head_valid && !fifo_empty && !stall && !redirect_valid;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Stale-response count: a redirect discards everything still in flight
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid)  drop_nxt = outstanding - CW'(imem_rsp_valid);
    else if (rsp_drop)   drop_nxt = drop_cnt - CW'(1);
  end

  // Address counters and credit tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(hs) - CW'(imem_rsp_valid);
      drop_cnt    <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        rsp_pc   <= word_align(redirect_pc);
      end else begin
        if (hs)         fetch_pc <= fetch_pc + 32'd4;
        if (rsp_accept) rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next state: redirects pick the mode, DRAIN ends once stale responses are gone
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) state_nxt = HOLD;
      else if (drop_nxt != '0)       state_nxt = DRAIN;
      else                           state_nxt = FETCH;
    end else if (state == DRAIN && drop_nxt == '0) begin
      state_nxt = FETCH;
    end
  end

  // Outputs: request port and IF/ID-facing head entry
  always_comb begin
    imem_req_valid = reset && (state != HOLD) && !redirect_valid && (credits_used < DEPTH_W);
    imem_req_addr  = fetch_pc;
    head_valid     = (state != HOLD) && (!fifo_empty || bypass);
    head_sel       = fifo_empty ? rsp_entry : fifo_head;
    if_valid       = head_valid;
    if_pc          = head_valid ? head_sel.pc : 32'd0;
    if_instr       = head_valid ? head_sel.instr : NOP_INSTR;
    if_pc_plus_4   = if_pc + 32'd4;
    o_occupancy    = fifo_count;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue with an in-order memory model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] TAG   = 32'h1300_0000;

  logic          clk = 1'b0, reset = 1'b0;
  logic          imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          stall = 1'b0;
  logic          if_valid;
  logic [31:0]   if_pc, if_pc_plus_4, if_instr;
  logic [CW-1:0] o_occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4), .if_instr(if_instr),
    .o_occupancy(o_occupancy)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int          errors = 0, checks = 0;
  mreq_t       mem_q[$];      // requests in flight at the memory
  logic [31:0] exp_q[$];      // pcs the consumer should see, in order
  logic [31:0] model_pc = RPC;
  bit          hold = 0, hold_next = 0;
  int          cyc = 0, last_due = 0, lat = 1, consumed = 0;
  bit          c_reset = 0, c_stall = 0, c_ready = 0, c_redir = 0;
  logic [31:0] c_tgt = '0;
  bit          want_redir = 0, redir_fired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, then account for the handshakes of the coming edge
  task automatic cycle();
    bit rsp_now;
    int due, used;
    @(negedge clk);
    hold           = hold_next;
    reset          = c_reset;
    stall          = c_stall;
    imem_req_ready = c_ready;
    redirect_valid = c_redir;
    redirect_pc    = c_tgt;
    rsp_now        = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].addr | TAG;
      void'(mem_q.pop_front());
      rsp_now = 1;
    end
    if (want_redir && rsp_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = c_tgt;
      want_redir     = 0;
      redir_fired    = 1;
    end
    #1;
    if (!reset) begin
      mem_q.delete();
      exp_q.delete();
      model_pc  = RPC;
      hold_next = 0;
      last_due  = cyc;
    end else begin
      used = int'(o_occupancy) + mem_q.size() + int'(rsp_now);
      chk("credit_limit", 32'(used <= DEPTH), 32'd1);
      if (redirect_valid) begin
        chk("req_during_redirect", 32'(imem_req_valid), 32'd0);
        exp_q.delete();
        model_pc  = {redirect_pc[31:2], 2'b00};
        hold_next = (redirect_pc[1:0] != 2'b00);
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{imem_req_addr, due});
        exp_q.push_back(model_pc);
        model_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: every consumed head entry must be the oldest expected fetch
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("pc_plus_4", if_pc_plus_4, if_pc + 32'd4);
        if (!if_valid) chk("nop_when_invalid", if_instr, NOP);
        if (hold) begin
          chk("hold_req_valid", 32'(imem_req_valid), 32'd0);
          chk("hold_if_valid", 32'(if_valid), 32'd0);
        end
        if (if_valid && !stall && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got pc %h expected no entry", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e);
            chk("if_instr", if_instr, e | TAG);
            consumed++;
          end
        end
      end
    end
  end

  initial begin
    int base;
    // Reset state
    c_reset = 0; c_ready = 1;
    cycle(); cycle(); #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_pc_plus_4", if_pc_plus_4, 32'd4);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_occupancy", 32'(o_occupancy), 32'd0);

    // Streaming with single-cycle memory
    c_reset = 1; lat = 1; base = consumed;
    run(20);
    chk("stream_progress", 32'(consumed - base >= 10), 32'd1);

    // Long stall fills the queue and stops requests
    c_stall = 1;
    run(8); #1;
    chk("stall_full_occ", 32'(o_occupancy), DEPTH);
    chk("stall_no_req", 32'(imem_req_valid), 32'd0);
    c_stall = 0; base = consumed;
    run(12);
    chk("stall_resume", 32'(consumed - base >= 6), 32'd1);

    // Redirect with slow memory and stale responses in flight
    lat = 3;
    run(6);
    c_redir = 1; c_tgt = 32'h0000_0100;
    cycle();
    c_redir = 0; base = consumed;
    run(20);
    chk("redirect_progress", 32'(consumed - base >= 4), 32'd1);

    // Misaligned target parks the front end until the next redirect
    c_redir = 1; c_tgt = 32'h0000_0102;
    cycle();
    c_redir = 0;
    run(10); #1;
    chk("hold_nop", if_instr, NOP);
    chk("hold_no_req", 32'(imem_req_valid), 32'd0);
    c_redir = 1; c_tgt = 32'h0000_0200;
    cycle();
    c_redir = 0; base = consumed;
    run(20);
    chk("hold_exit_progress", 32'(consumed - base >= 4), 32'd1);

    // Redirect together with a response while stalled
    c_stall = 1; want_redir = 1; redir_fired = 0; c_tgt = 32'h0000_0300;
    for (int i = 0; i < 50 && !redir_fired; i++) cycle();
    chk("redir_with_rsp_seen", 32'(redir_fired), 32'd1);
    want_redir = 0;
    cycle(); #1;
    chk("flush_under_stall", 32'(o_occupancy), 32'd0);
    c_stall = 0; base = consumed;
    run(20);
    chk("flush_progress", 32'(consumed - base >= 4), 32'd1);

    // Back-to-back redirects: the later target wins
    c_redir = 1; c_tgt = 32'h0000_0400; cycle();
    c_tgt = 32'h0000_0500; cycle();
    c_redir = 0;
    run(15);

    // Mid-stream reset with requests outstanding
    for (int i = 0; i < 30 && mem_q.size() < 3; i++) cycle();
    chk("outstanding_before_reset", 32'(mem_q.size() >= 3), 32'd1);
    c_reset = 0; cycle();
    c_reset = 1; cycle(); #1;
    chk("post_rst_occ", 32'(o_occupancy), 32'd0);
    chk("post_rst_if_valid", 32'(if_valid), 32'd0);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RPC);
    base = consumed;
    run(20);
    chk("post_rst_progress", 32'(consumed - base >= 4), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      c_ready = ($urandom_range(0, 3) != 0);
      c_stall = ($urandom_range(0, 3) == 0);
      lat     = $urandom_range(1, 4);
      c_redir = ($urandom_range(0, 19) == 0);
      c_tgt   = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
      cycle();
    end
    c_redir = 1; c_tgt = 32'h0000_0800; c_stall = 0; c_ready = 1;
    cycle();
    c_redir = 0; base = consumed;
    run(20);
    chk("final_progress", 32'(consumed - base >= 4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of the 5-stage pipeline datapath IF/ID register. It replaces the combinational instruction-memory lookup with a request/response memory port that can take several cycles, and buffers fetched {pc, instr} pairs in a small FIFO. It honours hazard-unit stalls and EX-stage redirects: taken branch, jal, jalr.

Parameters:
DEPTH, 4, FIFO entries and maximum outstanding requests (power of 2, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction presented when no valid entry (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in-order, no backpressure
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  EX-stage pc_sel!=0 (flush)
redirect_pc  in  32  branch/jump/jalr target
stall  in  1  hazard-unit stall; head entry must not be consumed
if_valid  out  1  head entry valid
if_pc  out  32  head pc
if_pc_plus_4  out  32  if_pc + 4, modulo 2^32
if_instr  out  32  head instruction, or NOP_INSTR when if_valid==0
o_occupancy  out  log2(DEPTH)+1  FIFO count, for diagnostics

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=FETCH.
  - Outputs: imem_req_valid=0, if_valid=0, if_pc=0, if_pc_plus_4=4, if_instr=NOP_INSTR, o_occupancy=0.
  - A reset mid-operation discards all outstanding responses by construction. The memory is reset by the same reset.
- Request issue:
  - imem_req_valid = (state!=HOLD) && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - Handshake (valid && ready): fetch_pc += 4, wrapping at 2^32; outstanding += 1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: drop_cnt -= 1 and the data is discarded.
  - Otherwise, push {pc, data}. The entry pc comes from an internal rsp_pc counter that tracks the address of the oldest outstanding request.
- Consume: the head pops when if_valid && !stall. Push and pop in the same cycle leave count unchanged. A full FIFO cannot occur on push because credits prevent it.
- Latency: a response is visible at if_* on the cycle after imem_rsp_valid (without bypass).
- Redirect (redirect_valid=1 at posedge):
  - FIFO cleared (count=0).
  - fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − (rsp_valid this cycle ? 1 : 0).
  - The response arriving in the same cycle is discarded.
  - Redirect overrides stall and pop.
- States:
  - FETCH (normal).
  - DRAIN: drop_cnt>0. Requests are still issued, since in-order responses guarantee the old ones drain first. Return to FETCH when drop_cnt reaches 0.
  - HOLD: entered when redirect_pc[1:0]!=0. No requests are issued and if_valid=0 until the next redirect or reset. Only the low bits are forced to zero, as stated above.
- Consecutive redirects on back-to-back cycles: the latest one wins, and drop_cnt is recomputed each time.

Optional Feature:
FETCH_QUEUE_BYPASS_EN.
- Defined: when the FIFO is empty, drop_cnt==0 and imem_rsp_valid=1, the response drives if_* combinationally in the same cycle. It is pushed only if it is not consumed (stall=1). This gives zero-cycle added latency.
- Undefined: every response passes through the FIFO, giving one-cycle latency, and if_* come purely from registers.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INSTR
  - the state enum FETCH/DRAIN/HOLD
  - the typedef fetch_entry_t {pc[31:0], instr[31:0]}
- One natural sub-module, sync_fifo: parameterised DEPTH × 64-bit, with push/pop/clear/count. The top level holds the credit counters, drop logic and FSM.

Test Plan:
1. Reset release, imem_req_ready=1, responses 1 cycle after each request with data=addr|0x13000000, no stall → imem_req_addr 0,4,8,…; if_pc follows 0,4,8 with if_valid=1 from cycle 3 onward; if_pc_plus_4=if_pc+4.
2. Hold stall=1 for 8 cycles → requests stop when count+outstanding=4; o_occupancy=4; if_pc frozen at 0x0; release stall → resumes 0x4 with no loss or duplication.
3. Memory latency 3 cycles, 2 requests outstanding; redirect_valid with redirect_pc=0x100 → both stale responses dropped; next if_pc=0x100, if_instr = response to 0x100; no stale pc appears.
4. redirect_pc=0x102 → state HOLD; imem_req_valid=0 and if_instr=0x00000013 for 10 cycles; redirect to 0x200 → fetch resumes at 0x200.
5. Redirect and imem_rsp_valid in the same cycle while stall=1 → response discarded, FIFO cleared, stall ignored for the flush, next valid if_pc = target.
6. Drive reset=0 for 1 cycle mid-stream with 3 outstanding → all outputs return to reset values; first request after reset is at 0x0; pre-reset responses never appear on if_*.
